mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Memory-side bus sequencer directly downstream of the CPU core; converts single-cycle CPU access requests into SM83-style 4-T-cycle machine cycles on the external memory bus.
- Drives the external address, data and strobe pins.
- Captures read data and returns it to the core with a one-cycle done pulse.
- Supports fixed wait states, an external wait input and a wait timeout.
- Uses split in/out data buses; tristating happens at chip top.

Parameters:
- WAIT_STATES, 0, extra T3 cycles inserted on every access (0..15).
- TIMEOUT, 255, max cycles mem_wait may extend T3 before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  CPU access request; sampled only in IDLE or T4.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  16  access address; sampled with req.
- wdata  in  8  write data; sampled with req.
- rdata  out  8  read data; valid from the done cycle until the next read's done.
- done  out  1  one-cycle pulse in T4.
- err  out  1  one-cycle pulse with done on timeout abort.
- busy  out  1  high in T1..T4.
- mem_addr  out  16  external address, latched.
- mem_dout  out  8  external write data, latched.
- mem_dout_en  out  1  write-data drive enable for the top-level tristate.
- mem_din  in  8  external read data.
- mem_cs  out  1  chip select, active-high.
- mem_oe  out  1  output enable (read strobe), active-high.
- mem_we  out  1  write strobe, active-high.
- mem_wait  in  1  external wait request, active-high.

Behaviour:
- Reset: all outputs 0, state IDLE, both counters 0.
- Reset mid-access: on the next edge all strobes drop to 0 and state returns to IDLE. The transaction is discarded; no done or err pulse.
- FSM states: IDLE, T1, T2, T3, T4.
- Request acceptance: an edge with req=1 in IDLE or T4 latches addr, we and wdata into mem_addr, the internal write flag and mem_dout, then moves to T1. Otherwise T4 goes to IDLE. req is ignored in T1..T3.
- T1: mem_cs=1; oe/we/dout_en all 0 (address setup).
- T2: mem_cs=1. Read: mem_oe=1. Write: mem_we=1 and mem_dout_en=1. Wait counter loads WAIT_STATES; timeout counter clears.
- T3: strobes as in T2.
  - If wait counter != 0: decrement and stay.
  - Else if mem_wait=1: stay and increment the timeout counter. If TIMEOUT != 0 and the counter reaches TIMEOUT, leave for T4 with abort flagged.
  - Else: leave for T4.
  - Read, normal exit: the edge leaving T3 captures mem_din into rdata.
- T4: mem_cs=1, mem_oe=0, mem_we=0. mem_dout_en stays 1 for writes (data hold), 0 for reads. done=1.
  - Abort: err=1, and a read loads rdata=8'hFF.
  - mem_addr and mem_dout hold until the next acceptance.
- Latency: req accepted at edge n gives T1..T4 in cycles n+1..n+4, with done in n+4. Total cycles = 4 + WAIT_STATES + mem_wait cycles.
- Back-to-back: req held high yields one access per 4 cycles (no wait states); busy stays continuously 1.
- mem_wait is ignored outside T3, and in T3 while the wait counter is nonzero (fixed waits and external waits do not overlap).
- done and err are never high outside T4; err is never high without done.
- Counter widths: 4-bit wait counter, 8-bit timeout counter; neither wraps.

Test Plan:
- Read, WAIT_STATES=0: req, we=0, addr=16'hC012, mem_din=8'h5A → mem_cs high 4 cycles; mem_oe high exactly in T2, T3; done and rdata=8'h5A in cycle n+4; busy 1 for cycles n+1..n+4.
- Write: addr=16'hFF80, wdata=8'h3C → mem_we high exactly T2, T3; mem_dout=8'h3C with mem_dout_en high T2..T4; rdata unchanged.
- Waits, WAIT_STATES=2 plus mem_wait held 3 cycles after the fixed waits → done at n+9 (4+2+3); read data sampled on the final T3 edge.
- Timeout, TIMEOUT=4, mem_wait stuck high on a read → done=1 and err=1 in the same cycle, rdata=8'hFF, mem_cs drops the following cycle.
- Back-to-back: req held high with 3 alternating read/write addresses → 12 consecutive busy cycles, done every 4th cycle, mem_addr updating at each T1.
- Reset in T3 of a write → next cycle mem_cs=mem_we=mem_dout_en=0, busy=0; no done pulse; a following read completes normally.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns single-cycle core requests into 4-T-cycle
// external bus accesses with fixed/external wait states and timeout.
module mem_bus_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_dout_en,
    input  logic [7:0]  mem_din,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic        mem_wait
);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        T4
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state;
    logic        is_wr;
    logic [3:0]  wait_cnt;
    logic [7:0]  to_cnt;
    logic [7:0]  to_next;
    logic        to_hit;
    logic        accept;

    assign accept  = req && (state == IDLE || state == T4);
    // Saturate so a disabled timeout never wraps back through zero.
    assign to_next = (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;
    assign to_hit  = (TIMEOUT != 0) && (to_next == TO);

    // Bus sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            is_wr       <= 1'b0;
            wait_cnt    <= 4'd0;
            to_cnt      <= 8'd0;
            rdata       <= 8'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= 16'd0;
            mem_dout    <= 8'd0;
            mem_dout_en <= 1'b0;
            mem_cs      <= 1'b0;
            mem_oe      <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE, T4: begin
                    mem_oe      <= 1'b0;
                    mem_we      <= 1'b0;
                    mem_dout_en <= 1'b0;
                    if (accept) begin
                        state    <= T1;
                        mem_addr <= addr;
                        mem_dout <= wdata;
                        is_wr    <= we;
                        mem_cs   <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        mem_cs <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                T1: begin
                    state       <= T2;
                    mem_oe      <= ~is_wr;
                    mem_we      <= is_wr;
                    mem_dout_en <= is_wr;
                    wait_cnt    <= WS;
                    to_cnt      <= 8'd0;
                end
                T2: begin
                    state <= T3;
                end
                T3: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (mem_wait && !to_hit) begin
                        to_cnt <= to_next;
                    end else begin
                        // Leave for T4; abort when the wait ran out.
                        state  <= T4;
                        to_cnt <= mem_wait ? to_next : to_cnt;
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        err    <= mem_wait;
                        if (!is_wr) begin
                            rdata <= mem_wait ? 8'hFF : mem_din;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_cs      <= 1'b0;
                    mem_oe      <= 1'b0;
                    mem_we      <= 1'b0;
                    mem_dout_en <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed checks of read, write, waits, timeout,
// back-to-back and mid-access reset.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        req0;
    logic        req1;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mem_din;
    logic        mem_wait;

    logic [7:0]  rdata0, rdata1;
    logic        done0, done1;
    logic        err0, err1;
    logic        busy0, busy1;
    logic [15:0] mem_addr0, mem_addr1;
    logic [7:0]  mem_dout0, mem_dout1;
    logic        dout_en0, dout_en1;
    logic        cs0, cs1;
    logic        oe0, oe1;
    logic        mwe0, mwe1;

    int n_chk;
    int n_fail;

    mem_bus_ctrl #(.WAIT_STATES(0), .TIMEOUT(4)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .req         (req0),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata0),
        .done        (done0),
        .err         (err0),
        .busy        (busy0),
        .mem_addr    (mem_addr0),
        .mem_dout    (mem_dout0),
        .mem_dout_en (dout_en0),
        .mem_din     (mem_din),
        .mem_cs      (cs0),
        .mem_oe      (oe0),
        .mem_we      (mwe0),
        .mem_wait    (mem_wait)
    );

    mem_bus_ctrl #(.WAIT_STATES(2), .TIMEOUT(255)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .req         (req1),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata1),
        .done        (done1),
        .err         (err1),
        .busy        (busy1),
        .mem_addr    (mem_addr1),
        .mem_dout    (mem_dout1),
        .mem_dout_en (dout_en1),
        .mem_din     (mem_din),
        .mem_cs      (cs1),
        .mem_oe      (oe1),
        .mem_we      (mwe1),
        .mem_wait    (mem_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ba [3];

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        req0     = 1'b0;
        req1     = 1'b0;
        we       = 1'b0;
        addr     = 16'd0;
        wdata    = 8'd0;
        mem_din  = 8'd0;
        mem_wait = 1'b0;
        n_chk    = 0;
        n_fail   = 0;
        ba[0]    = 16'h1000;
        ba[1]    = 16'h2000;
        ba[2]    = 16'h3000;

        cyc();
        cyc();
        chk("rst_cs", 32'(cs0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_rdata", 32'(rdata0), 0);
        chk("rst_maddr", 32'(mem_addr0), 0);
        chk("rst_busy1", 32'(busy1), 0);
        rst = 1'b0;
        cyc();

        // Read, no waits
        addr = 16'hC012; we = 1'b0; mem_din = 8'h5A; req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        chk("rd_t1_cs", 32'(cs0), 1);
        chk("rd_t1_oe", 32'(oe0), 0);
        chk("rd_t1_busy", 32'(busy0), 1);
        chk("rd_t1_addr", 32'(mem_addr0), 32'hC012);
        cyc();
        chk("rd_t2_oe", 32'(oe0), 1);
        chk("rd_t2_done", 32'(done0), 0);
        cyc();
        chk("rd_t3_oe", 32'(oe0), 1);
        chk("rd_t3_cs", 32'(cs0), 1);
        cyc();
        chk("rd_t4_done", 32'(done0), 1);
        chk("rd_t4_rdata", 32'(rdata0), 32'h5A);
        chk("rd_t4_oe", 32'(oe0), 0);
        chk("rd_t4_cs", 32'(cs0), 1);
        chk("rd_t4_err", 32'(err0), 0);
        chk("rd_t4_busy", 32'(busy0), 1);
        cyc();
        chk("rd_idle_cs", 32'(cs0), 0);
        chk("rd_idle_busy", 32'(busy0), 0);
        chk("rd_idle_done", 32'(done0), 0);

        // Write
        addr = 16'hFF80; we = 1'b1; wdata = 8'h3C; mem_din = 8'hE1;
        req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        chk("wr_t1_we", 32'(mwe0), 0);
        chk("wr_t1_den", 32'(dout_en0), 0);
        chk("wr_t1_dout", 32'(mem_dout0), 32'h3C);
        cyc();
        chk("wr_t2_we", 32'(mwe0), 1);
        chk("wr_t2_den", 32'(dout_en0), 1);
        chk("wr_t2_oe", 32'(oe0), 0);
        cyc();
        chk("wr_t3_we", 32'(mwe0), 1);
        cyc();
        chk("wr_t4_we", 32'(mwe0), 0);
        chk("wr_t4_den", 32'(dout_en0), 1);
        chk("wr_t4_done", 32'(done0), 1);
        chk("wr_t4_rdata", 32'(rdata0), 32'h5A);
        cyc();
        chk("wr_idle_den", 32'(dout_en0), 0);
        chk("wr_idle_addr", 32'(mem_addr0), 32'hFF80);

        // Timeout on a stuck read
        addr = 16'hC100; we = 1'b0; mem_din = 8'h77; mem_wait = 1'b1;
        req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("to_t3_done", 32'(done0), 0);
            chk("to_t3_oe", 32'(oe0), 1);
        end
        cyc();
        chk("to_done", 32'(done0), 1);
        chk("to_err", 32'(err0), 1);
        chk("to_rdata", 32'(rdata0), 32'hFF);
        mem_wait = 1'b0;
        cyc();
        chk("to_cs_drop", 32'(cs0), 0);
        chk("to_err_drop", 32'(err0), 0);

        // Back-to-back read/write/read
        addr = ba[0]; we = 1'b0; wdata = 8'h99; req0 = 1'b1;
        cyc();
        for (int k = 1; k <= 12; k++) begin
            chk("b2b_busy", 32'(busy0), 1);
            chk("b2b_done", 32'(done0), 32'(k % 4 == 0));
            chk("b2b_addr", 32'(mem_addr0), 32'(ba[(k - 1) / 4]));
            chk("b2b_we", 32'(mwe0), 32'(k == 6 || k == 7));
            if (k % 4 == 0 && k < 12) begin
                addr = ba[k / 4];
                we   = (k / 4 == 1);
            end
            if (k == 12) req0 = 1'b0;
            cyc();
        end
        chk("b2b_end_busy", 32'(busy0), 0);

        // Fixed waits then external waits
        addr = 16'hA0A0; we = 1'b0; mem_din = 8'h11; req1 = 1'b1;
        cyc();
        req1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            mem_din  = (k == 8) ? 8'hA7 : 8'h11;
            mem_wait = (k >= 5 && k <= 7);
            chk("ws_busy", 32'(busy1), 1);
            chk("ws_done", 32'(done1), 32'(k == 9));
            chk("ws_oe", 32'(oe1), 32'(k >= 2 && k <= 8));
            if (k == 9) chk("ws_rdata", 32'(rdata1), 32'hA7);
            if (k < 9) cyc();
        end
        mem_wait = 1'b0;
        cyc();
        chk("ws_end_busy", 32'(busy1), 0);
        chk("ws_end_err", 32'(err1), 0);

        // Reset in T3 of a write
        addr = 16'h4000; we = 1'b1; wdata = 8'h55; req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        cyc();
        cyc();
        chk("rs_t3_we", 32'(mwe0), 1);
        rst = 1'b1;
        cyc();
        chk("rs_cs", 32'(cs0), 0);
        chk("rs_we", 32'(mwe0), 0);
        chk("rs_den", 32'(dout_en0), 0);
        chk("rs_busy", 32'(busy0), 0);
        chk("rs_done", 32'(done0), 0);
        rst = 1'b0;
        cyc();
        chk("rs_done2", 32'(done0), 0);
        addr = 16'h5000; we = 1'b0; mem_din = 8'h6B; req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("rs_rd_done", 32'(done0), 1);
        chk("rs_rd_rdata", 32'(rdata0), 32'h6B);
        chk("rs_rd_err", 32'(err0), 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
